core_lsu: RTL and testbench



---
 rtl/core_pkg.sv | 43 ++++
 rtl/core_lsu_align.sv | 52 +++++
 rtl/core_lsu.sv | 118 +++++++++++
 tb/tb_core_lsu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: RISC-V load/store width codes, LSU FSM states and
// small request-decode helpers.
package core_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StResp
    } lsu_state_e;

    // Unsigned widths only exist for loads.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return we;
            default:          return 1'b1;
        endcase
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: return lo[0];
            F3_W:        return lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    // Truncate low address bits to the natural alignment of the access width.
    function automatic logic [1:0] natural_lo(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: return {lo[1], 1'b0};
            F3_W:        return 2'b00;
            default:     return lo;
        endcase
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Combinational lane logic for the LSU: store byte enables and lane replication,
// load lane select with sign/zero extension.
module core_lsu_align
    import core_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] rdata_sh;

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        if (we) begin
            case (funct3[1:0])
                2'b00: begin
                    be        = 4'b0001 << addr_lo;
                    wdata_rep = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be        = 4'b0011 << {addr_lo[1], 1'b0};
                    wdata_rep = {2{wdata[15:0]}};
                end
                default: begin
                    be        = 4'b1111;
                    wdata_rep = wdata;
                end
            endcase
        end
    end

    always_comb begin
        rdata_sh  = rdata >> {addr_lo, 3'b000};
        rdata_ext = 32'h0;
        case (funct3)
            F3_B:    rdata_ext = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            F3_BU:   rdata_ext = {24'h0, rdata_sh[7:0]};
            F3_H:    rdata_ext = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            F3_HU:   rdata_ext = {16'h0, rdata_sh[15:0]};
            F3_W:    rdata_ext = rdata;
            default: rdata_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// Core load/store unit: one request at a time onto the core data bus, held through
// wait states. Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of truncating.
module core_lsu
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        res,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] address,
    output logic [31:0] data_out,
    output logic [3:0]  BE,
    output logic        write_e,
    output logic        read_e,
    input  logic [31:0] data_in,
    input  logic        halt
);

    lsu_state_e  state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic [31:0] wdata_q;

    logic        req_err;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;

    always_comb begin
        req_err = f3_illegal(req_we, req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        req_err = req_err | f3_misaligned(req_funct3, req_addr[1:0]);
`endif
    end

    core_lsu_align u_align (
        .we        (we_q),
        .funct3    (f3_q),
        .addr_lo   (lo_q),
        .wdata     (wdata_q),
        .rdata     (data_in),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata)
    );

    // Lane outputs derive only from latched fields, so they stay constant while strobed.
    assign BE       = (write_e | read_e) ? al_be : 4'b0000;
    assign data_out = write_e ? al_wdata : 32'h0;

    always_ff @(posedge clk) begin
        if (res) begin
            state     <= StIdle;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            address   <= 32'h0;
            write_e   <= 1'b0;
            read_e    <= 1'b0;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            lo_q      <= 2'b00;
            wdata_q   <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (req_err) begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state   <= StBus;
                            we_q    <= req_we;
                            f3_q    <= req_funct3;
                            lo_q    <= natural_lo(req_funct3, req_addr[1:0]);
                            wdata_q <= req_wdata;
                            address <= {req_addr[31:2], 2'b00};
                            write_e <= req_we;
                            read_e  <= ~req_we;
                        end
                    end
                end
                StBus: begin
                    if (!halt) begin
                        state     <= StResp;
                        write_e   <= 1'b0;
                        read_e    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= we_q ? 32'h0 : al_rdata;
                    end
                end
                StResp: begin
                    state     <= StIdle;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= StIdle;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_lsu.sv
// Scoreboard bench for core_lsu: directed requests push expected responses,
// a monitor pops and compares on every rsp_valid.
module tb_core_lsu;

    logic        clk = 1'b0;
    logic        res;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] address;
    logic [31:0] data_out;
    logic [3:0]  BE;
    logic        write_e;
    logic        read_e;
    logic [31:0] data_in;
    logic        halt;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    core_lsu dut (
        .clk        (clk),
        .res        (res),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .address    (address),
        .data_out   (data_out),
        .BE         (BE),
        .write_e    (write_e),
        .read_e     (read_e),
        .data_in    (data_in),
        .halt       (halt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response pops the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid) begin
            chk("rsp_single_pulse", {31'h0, prev_valid}, 32'h0);
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                chk("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
        if (write_e || read_e)
            chk("strobe_exclusive", {31'h0, write_e & read_e}, 32'h0);
        prev_valid = rsp_valid;
    end

    task automatic check_bus(input string name, input bit we, input bit [3:0] be,
                             input bit [31:0] dout, input bit [31:0] addr);
        chk({name, "_we"}, {31'h0, write_e}, {31'h0, we});
        chk({name, "_re"}, {31'h0, read_e}, {31'h0, ~we});
        chk({name, "_be"}, {28'h0, BE}, {28'h0, be});
        chk({name, "_addr"}, address, addr);
        if (we) chk({name, "_dout"}, data_out, dout);
        chk({name, "_ready"}, {31'h0, req_ready}, 32'h0);
    endtask

    // Called just after a posedge; returns just after a posedge with the LSU idle.
    task automatic issue(input string name, input bit we, input bit [2:0] f3,
                         input bit [31:0] addr, input bit [31:0] wd, input int nhalt,
                         input bit [31:0] din, input bit exp_err, input bit [31:0] exp_rd,
                         input bit [3:0] exp_be, input bit [31:0] exp_dout,
                         input bit [31:0] exp_addr);
        int waited = 0;
        while (!req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!req_ready) begin
            chk({name, "_ready_timeout"}, 32'h0, 32'h1);
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        exp_q.push_back('{err: exp_err, rdata: exp_rd});
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        if (exp_err) begin
            @(negedge clk);
            chk({name, "_err_nostrobe"}, {30'h0, write_e, read_e}, 32'h0);
            chk({name, "_err_latency"}, {31'h0, rsp_valid}, 32'h1);
            @(posedge clk); #1;
            @(negedge clk);
            chk({name, "_err_nostrobe2"}, {30'h0, write_e, read_e}, 32'h0);
            @(posedge clk); #1;
        end else begin
            halt    = (nhalt > 0);
            data_in = 32'hFFFF_FFFF;
            for (int i = 0; i < nhalt; i++) begin
                @(negedge clk);
                check_bus({name, "_wait"}, we, exp_be, exp_dout, exp_addr);
                @(posedge clk); #1;
            end
            halt    = 1'b0;
            data_in = din;
            @(negedge clk);
            check_bus({name, "_done"}, we, exp_be, exp_dout, exp_addr);
            @(posedge clk); #1;
            halt    = 1'($urandom);
            data_in = $urandom;
            @(negedge clk);
            chk({name, "_resp_valid"}, {31'h0, rsp_valid}, 32'h1);
            chk({name, "_resp_nostrobe"}, {30'h0, write_e, read_e}, 32'h0);
            @(posedge clk); #1;
            halt = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        res = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; data_in = 32'h0; halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", {31'h0, req_ready}, 32'h1);
        chk("reset_rsp", {30'h0, rsp_valid, rsp_err}, 32'h0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        chk("reset_bus", {26'h0, BE, write_e, read_e}, 32'h0);
        chk("reset_addr", address, 32'h0);
        chk("reset_dout", data_out, 32'h0);
        res = 1'b0;
        @(posedge clk); #1;

        issue("sw", 1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1, 0, 0, 0, 4'b1111,
              32'hDEAD_BEEF, 32'h10);
        issue("sb", 1, 3'b000, 32'h0000_0013, 32'h1234_56A5, 0, 0, 0, 0, 4'b1000,
              32'hA5A5_A5A5, 32'h10);
        issue("sh", 1, 3'b001, 32'h0000_0022, 32'hCAFE_BEEF, 2, 0, 0, 0, 4'b1100,
              32'hBEEF_BEEF, 32'h20);
        issue("lb", 0, 3'b000, 32'h0000_0012, 0, 1, 32'h0080_0000, 0, 32'hFFFF_FF80,
              4'b1111, 0, 32'h10);
        issue("lbu", 0, 3'b100, 32'h0000_0012, 0, 0, 32'h0080_0000, 0, 32'h0000_0080,
              4'b1111, 0, 32'h10);
        issue("lhu", 0, 3'b101, 32'h0000_0002, 0, 1, 32'h0080_0000, 0, 32'h0000_0080,
              4'b1111, 0, 32'h0);
        issue("lh", 0, 3'b001, 32'h0000_0002, 0, 0, 32'h8000_0000, 0, 32'hFFFF_8000,
              4'b1111, 0, 32'h0);
        issue("lw_io", 0, 3'b010, 32'h8000_0004, 0, 1, 32'h1234_5678, 0, 32'h1234_5678,
              4'b1111, 0, 32'h8000_0004);
`ifdef LSU_MISALIGN_TRAP_EN
        issue("lw_mis", 0, 3'b010, 32'h0000_0006, 0, 0, 0, 1, 0, 0, 0, 0);
        issue("lh_mis", 0, 3'b001, 32'h0000_0003, 0, 0, 0, 1, 0, 0, 0, 0);
`else
        issue("lw_mis", 0, 3'b010, 32'h0000_0006, 0, 1, 32'hA1B2_C3D4, 0, 32'hA1B2_C3D4,
              4'b1111, 0, 32'h4);
        issue("lh_mis", 0, 3'b001, 32'h0000_0003, 0, 0, 32'h8001_0000, 0, 32'hFFFF_8001,
              4'b1111, 0, 32'h0);
`endif
        issue("st_f3_100", 1, 3'b100, 32'h0000_0000, 32'h1, 0, 0, 1, 0, 0, 0, 0);
        issue("ld_f3_011", 0, 3'b011, 32'h0000_0008, 0, 0, 0, 1, 0, 0, 0, 0);
        issue("ld_f3_111", 0, 3'b111, 32'h0000_0008, 0, 0, 0, 1, 0, 0, 0, 0);
        issue("sw_halt20", 1, 3'b010, 32'h0000_0040, 32'h0BAD_F00D, 20, 0, 0, 0, 4'b1111,
              32'h0BAD_F00D, 32'h40);

        // Reset during a stalled load: bus drops, no response for the aborted request.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        halt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_strobe", {31'h0, read_e}, 32'h1);
        res = 1'b1;
        @(posedge clk); #1;
        res = 1'b0;
        halt = 1'b0;
        chk("abort_bus", {26'h0, BE, write_e, read_e}, 32'h0);
        chk("abort_addr", address, 32'h0);
        chk("abort_dout", data_out, 32'h0);
        chk("abort_ready", {31'h0, req_ready}, 32'h1);
        chk("abort_norsp", {31'h0, rsp_valid}, 32'h0);
        repeat (4) @(posedge clk);
        #1;

        issue("sb_post", 1, 3'b000, 32'h0000_0001, 32'h0000_005A, 0, 0, 0, 0, 4'b0010,
              32'h5A5A_5A5A, 32'h0);

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
